piso_stream: RTL and testbench

PISO_STREAM -- requirements
Module: piso_stream

---
 rtl/bch_pkg.sv | 16 +
 rtl/piso_stream.sv | 100 ++++++++++
 tb/tb_piso_stream.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// Shared constants and state encoding for the BCH(15,7) codeword path.
// BCH_N / BCH_K describe the code; PISO_WIDTH_DEF is the serialiser's
// default frame width (one full codeword). piso_state_e is the serialiser
// state type.
package bch_pkg;

  localparam int BCH_N          = 15;
  localparam int BCH_K          = 7;
  localparam int PISO_WIDTH_DEF = BCH_N;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

endpackage

// File: rtl/piso_stream.sv
// Parallel-in / serial-out codeword streamer with valid/ready handshakes on
// both sides. One frame of WIDTH bits is loaded on an input handshake and
// sent one bit per output handshake. A new frame may load on the same edge
// as the last bit of the previous one, so back-to-back frames have no gap.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_data    parallel codeword (WIDTH bits)
//   in_valid   in_data valid
//   in_ready   block accepts in_data this cycle
//   out_bit    current serial bit (IDLE_BIT when nothing is held)
//   out_valid  out_bit valid
//   out_ready  sink consumes out_bit this cycle
//   out_first  out_bit is the first bit of the frame
//   out_last   out_bit is the last bit of the frame
//   busy       a frame is held
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no frame held, ready for a new codeword
// ST_SHIFT | frame held, cnt = index of the bit currently on out_bit
module piso_stream
  import bch_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  piso_state_e      state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             at_last;
  logic             in_hs;
  logic             out_hs;

  assign at_last   = (state == ST_SHIFT) && (cnt == CNT_LAST);
  assign busy      = (state == ST_SHIFT);
  assign out_valid = busy;
  assign out_first = busy && (cnt == '0);
  assign out_last  = at_last;
  assign out_bit   = busy ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : IDLE_BIT;

  // Gated by reset so in_ready reads 0 while reset is held even though the
  // state register already sits in ST_IDLE.
  assign in_ready = reset && ((state == ST_IDLE) || (at_last && out_ready));

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    if (in_hs) begin
      // Covers both a load from idle and a reload on the last bit.
      state_nxt = ST_SHIFT;
      sreg_nxt  = in_data;
      cnt_nxt   = '0;
    end else if (out_hs) begin
      if (at_last) begin
        state_nxt = ST_IDLE;
        sreg_nxt  = '0;
        cnt_nxt   = '0;
      end else begin
        sreg_nxt = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
        cnt_nxt  = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three instances (15-bit MSB-first, 15-bit
// LSB-first, 2-bit MSB-first) checked every cycle against a frame-level
// reference model that indexes the loaded word directly.
module tb_piso_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv_ab, ordy_ab;
  logic [14:0] dat_ab;
  logic        iv_c, ordy_c;
  logic [1:0]  dat_c;
  logic [2:0]  ir, ov, ob, fst, lst, bz;

  piso_stream #(.WIDTH(15), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .in_data(dat_ab), .in_valid(iv_ab), .in_ready(ir[0]),
    .out_bit(ob[0]), .out_valid(ov[0]), .out_ready(ordy_ab),
    .out_first(fst[0]), .out_last(lst[0]), .busy(bz[0]));

  piso_stream #(.WIDTH(15), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(dat_ab), .in_valid(iv_ab), .in_ready(ir[1]),
    .out_bit(ob[1]), .out_valid(ov[1]), .out_ready(ordy_ab),
    .out_first(fst[1]), .out_last(lst[1]), .busy(bz[1]));

  piso_stream #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_w2 (
    .clk(clk), .reset(reset), .in_data(dat_c), .in_valid(iv_c), .in_ready(ir[2]),
    .out_bit(ob[2]), .out_valid(ov[2]), .out_ready(ordy_c),
    .out_first(fst[2]), .out_last(lst[2]), .busy(bz[2]));

  int          m_w   [3] = '{15, 15, 2};
  bit          m_msb [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] m_word[3];
  int          m_pos [3];
  bit          m_act [3];

  logic [63:0] cap[3];
  int          ncap[3];
  int          nfirst[3];
  int          nlast[3];
  bit          cap_en;
  int          run, max_run;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic in_v(input int d);
    return (d == 2) ? iv_c : iv_ab;
  endfunction

  function automatic logic [63:0] in_d(input int d);
    return (d == 2) ? 64'(dat_c) : 64'(dat_ab);
  endfunction

  function automatic logic o_r(input int d);
    return (d == 2) ? ordy_c : ordy_ab;
  endfunction

  function automatic logic exp_ir(input int d);
    return reset && (!m_act[d] || ((m_pos[d] == m_w[d] - 1) && o_r(d)));
  endfunction

  function automatic logic exp_bit(input int d);
    if (!m_act[d]) return 1'b0;
    return m_msb[d] ? m_word[d][m_w[d] - 1 - m_pos[d]] : m_word[d][m_pos[d]];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_act[d]  = 1'b0;
      m_pos[d]  = 0;
      m_word[d] = '0;
    end
  endtask

  // Applied at a rising edge with the inputs that were present at it.
  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else begin
      for (int d = 0; d < 3; d++) begin
        bit ihs, ohs;
        ihs = in_v(d) && exp_ir(d);
        ohs = m_act[d] && o_r(d);
        if (ihs) begin
          m_word[d] = in_d(d);
          m_pos[d]  = 0;
          m_act[d]  = 1'b1;
        end else if (ohs) begin
          if (m_pos[d] == m_w[d] - 1) m_act[d] = 1'b0;
          else m_pos[d]++;
        end
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s.%0d.in_ready", ph, d), 64'(ir[d]), 64'(exp_ir(d)));
      chk($sformatf("%s.%0d.out_valid", ph, d), 64'(ov[d]), 64'(m_act[d]));
      chk($sformatf("%s.%0d.out_bit", ph, d), 64'(ob[d]), 64'(exp_bit(d)));
      chk($sformatf("%s.%0d.out_first", ph, d), 64'(fst[d]), 64'(m_act[d] && m_pos[d] == 0));
      chk($sformatf("%s.%0d.out_last", ph, d), 64'(lst[d]), 64'(m_act[d] && m_pos[d] == m_w[d] - 1));
      chk($sformatf("%s.%0d.busy", ph, d), 64'(bz[d]), 64'(m_act[d]));
    end
  endtask

  task automatic clear_cap();
    for (int d = 0; d < 3; d++) begin
      cap[d] = '0; ncap[d] = 0; nfirst[d] = 0; nlast[d] = 0;
    end
    run = 0; max_run = 0;
  endtask

  // Observe pre-edge outputs, advance one clock, update model, check.
  task automatic tick(input string ph);
    if (cap_en) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && o_r(d) && ncap[d] < 64) begin
          if (m_msb[d]) cap[d] = {cap[d][62:0], ob[d]};
          else cap[d][ncap[d]] = ob[d];
          ncap[d]++;
        end
        if (fst[d]) nfirst[d]++;
        if (lst[d]) nlast[d]++;
      end
      if (ov[0]) run++;
      else run = 0;
      if (run > max_run) max_run = run;
    end
    @(posedge clk);
    model_step();
    #2;
    check_all(ph);
  endtask

  initial begin
    reset = 1'b1;
    iv_ab = 1'b0; ordy_ab = 1'b0; dat_ab = '0;
    iv_c = 1'b0; ordy_c = 1'b0; dat_c = '0;
    cap_en = 1'b0;
    model_reset();
    clear_cap();
    #1 reset = 1'b0;
    #2 check_all("reset");
    tick("in_reset");
    tick("in_reset");
    @(negedge clk);
    reset = 1'b1;
    #1 check_all("release");

    // single frame, both bit orders
    cap_en = 1'b1;
    clear_cap();
    iv_ab = 1'b1; dat_ab = 15'h4D2F; ordy_ab = 1'b1;
    tick("load");
    iv_ab = 1'b0;
    repeat (16) tick("frame");
    chk("seq_msb", cap[0], 64'h4D2F);
    chk("seq_lsb", cap[1], 64'h4D2F);
    chk("seq_nbits", 64'(ncap[0]), 64'd15);

    // back-to-back frames, in_valid held
    clear_cap();
    iv_ab = 1'b1; dat_ab = 15'h7FFF;
    tick("b2b_load");
    dat_ab = 15'h0000;
    repeat (15) tick("b2b");
    iv_ab = 1'b0;
    repeat (16) tick("b2b_tail");
    chk("b2b_run", 64'(max_run), 64'd30);
    chk("b2b_bits", cap[0], 64'h3FFF_8000);
    chk("b2b_first", 64'(nfirst[0]), 64'd2);
    chk("b2b_last", 64'(nlast[0]), 64'd2);

    // backpressure 1,0,0,1
    clear_cap();
    iv_ab = 1'b1; dat_ab = 15'h4D2F; ordy_ab = 1'b1;
    tick("bp_load");
    iv_ab = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ordy_ab = (i % 4 == 0) || (i % 4 == 3);
      tick("bp");
    end
    chk("bp_msb", cap[0], 64'h4D2F);
    chk("bp_lsb", cap[1], 64'h4D2F);

    // reset mid-frame at bit 6, then a fresh frame
    clear_cap();
    iv_ab = 1'b1; dat_ab = 15'h4D2F; ordy_ab = 1'b1;
    tick("mr_load");
    iv_ab = 1'b0;
    repeat (5) tick("mr_frame");
    chk("mr_pos", 64'(m_pos[0]), 64'd5);
    #1 reset = 1'b0;
    #1 model_reset();
    check_all("mid_reset");
    tick("mr_hold");
    @(negedge clk);
    reset = 1'b1;
    #1 check_all("mr_release");
    clear_cap();
    iv_ab = 1'b1; dat_ab = 15'h0001;
    tick("mr_reload");
    iv_ab = 1'b0;
    repeat (16) tick("mr_frame2");
    chk("mr_msb", cap[0], 64'h0001);
    chk("mr_lsb", cap[1], 64'h0001);
    chk("mr_first", 64'(nfirst[0]), 64'd1);
    chk("mr_last", 64'(nlast[0]), 64'd1);

    // 2-bit build
    clear_cap();
    iv_c = 1'b1; dat_c = 2'b10; ordy_c = 1'b1;
    tick("w2_load");
    iv_c = 1'b0;
    repeat (3) tick("w2");
    chk("w2_bits", cap[2], 64'h2);
    chk("w2_first", 64'(nfirst[2]), 64'd1);
    chk("w2_last", 64'(nlast[2]), 64'd1);

    // randomized traffic on all instances
    cap_en = 1'b0;
    for (int i = 0; i < 800; i++) begin
      iv_ab   = 1'($urandom_range(0, 1));
      dat_ab  = 15'($urandom);
      ordy_ab = ($urandom_range(0, 3) != 0);
      iv_c    = 1'($urandom_range(0, 1));
      dat_c   = 2'($urandom);
      ordy_c  = ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
